// File: rtl/corr_host_master.sv
// Bus-master sequencer: loads one correlation job into the coprocessor, handshakes sync/ack, reads back four lags.
// Optional poll timeout is compiled in when CORR_HOST_TIMEOUT_EN is defined.
module corr_host_master #(
  parameter int unsigned POLL_LIMIT = 1023
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] tmpl_data,
  input  logic [159:0] sig_data,
  output logic [7:0]   address,
  output logic         write,
  output logic [31:0]  writedata,
  output logic         read,
  input  logic [31:0]  readdata,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [31:0]  result0,
  output logic [31:0]  result1,
  output logic [31:0]  result2,
  output logic [31:0]  result3
);

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned N_WORDS = 9;
  localparam int unsigned N_LAGS  = 4;
  localparam int unsigned IDX_W   = 4;

  localparam logic [ADDR_W-1:0] ADDR_SYNC = 8'h0A;
  localparam logic [ADDR_W-1:0] ADDR_ACK  = 8'h0B;
  localparam logic [ADDR_W-1:0] ADDR_RES  = 8'h10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_DATA,
    S_WR_SYNC1,
    S_POLL1,
    S_RD_RES,
    S_WR_SYNC0,
    S_POLL0,
    S_TMO_CLR,
    S_DONE
  } state_e;

  state_e                         state_q, state_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [N_WORDS-1:0][DATA_W-1:0] snap_q, snap_d;
  logic [N_LAGS-1:0][DATA_W-1:0]  result_q, result_d;
  logic                           err_q, err_d;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;
  logic [ADDR_W-1:0]              address_q, address_d;
  logic                           write_q, write_d;
  logic                           read_q, read_d;
  logic [DATA_W-1:0]              writedata_q, writedata_d;
  logic                           poll_expire_c;

`ifdef CORR_HOST_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(POLL_LIMIT + 1);

  logic [CNT_W-1:0] poll_cnt_q, poll_cnt_d;

  // Counts unanswered polls; restarts whenever a poll phase is entered.
  always_comb begin
    poll_cnt_d = '0;
    if (((state_q == S_POLL1) || (state_q == S_POLL0)) && (state_d == state_q)) begin
      poll_cnt_d = poll_cnt_q + CNT_W'(1);
    end
  end

  assign poll_expire_c = (poll_cnt_q == CNT_W'(POLL_LIMIT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      poll_cnt_q <= '0;
    end else begin
      poll_cnt_q <= poll_cnt_d;
    end
  end
`else
  logic unused_poll_limit;
  assign unused_poll_limit = ^POLL_LIMIT;
  assign poll_expire_c     = 1'b0;
`endif

  // Next-state, snapshot, result capture and registered bus/status outputs.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    snap_d      = snap_q;
    result_d    = result_q;
    err_d       = err_q;
    address_d   = '0;
    write_d     = 1'b0;
    read_d      = 1'b0;
    writedata_d = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          snap_d  = {sig_data, tmpl_data};
          err_d   = 1'b0;
          idx_d   = '0;
          state_d = S_WR_DATA;
        end
      end
      S_WR_DATA: begin
        if (idx_q == IDX_W'(N_WORDS - 1)) begin
          state_d = S_WR_SYNC1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_WR_SYNC1: state_d = S_POLL1;
      S_POLL1: begin
        if (readdata[0]) begin
          idx_d   = '0;
          state_d = S_RD_RES;
        end else if (poll_expire_c) begin
          err_d   = 1'b1;
          state_d = S_TMO_CLR;
        end
      end
      S_RD_RES: begin
        result_d[idx_q[1:0]] = readdata;
        if (idx_q == IDX_W'(N_LAGS - 1)) begin
          state_d = S_WR_SYNC0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_WR_SYNC0: state_d = S_POLL0;
      S_POLL0: begin
        if (!readdata[0]) begin
          state_d = S_DONE;
        end else if (poll_expire_c) begin
          err_d   = 1'b1;
          state_d = S_TMO_CLR;
        end
      end
      S_TMO_CLR: state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    // Bus outputs are registered, so they are derived from the upcoming state.
    unique case (state_d)
      S_WR_DATA: begin
        write_d     = 1'b1;
        address_d   = ADDR_W'(idx_d);
        writedata_d = snap_d[idx_d];
      end
      S_WR_SYNC1: begin
        write_d     = 1'b1;
        address_d   = ADDR_SYNC;
        writedata_d = DATA_W'(1);
      end
      S_POLL1, S_POLL0: begin
        read_d    = 1'b1;
        address_d = ADDR_ACK;
      end
      S_RD_RES: begin
        read_d    = 1'b1;
        address_d = ADDR_RES + ADDR_W'(idx_d);
      end
      S_WR_SYNC0, S_TMO_CLR: begin
        write_d   = 1'b1;
        address_d = ADDR_SYNC;
      end
      default: ;
    endcase

    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      snap_q      <= '0;
      result_q    <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      address_q   <= '0;
      write_q     <= 1'b0;
      read_q      <= 1'b0;
      writedata_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      snap_q      <= snap_d;
      result_q    <= result_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      address_q   <= address_d;
      write_q     <= write_d;
      read_q      <= read_d;
      writedata_q <= writedata_d;
    end
  end

  assign address   = address_q;
  assign write     = write_q;
  assign writedata = writedata_q;
  assign read      = read_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign result0   = result_q[0];
  assign result1   = result_q[1];
  assign result2   = result_q[2];
  assign result3   = result_q[3];

endmodule

// File: tb/tb_corr_host_master.sv
// Directed bench for corr_host_master with a behavioural correlation-coprocessor slave.
module tb_corr_host_master;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [127:0] tmpl_data;
  logic [159:0] sig_data;
  logic [7:0]   address;
  logic         write;
  logic [31:0]  writedata;
  logic         read;
  logic [31:0]  readdata;
  logic         busy, done, err;
  logic [31:0]  result0, result1, result2, result3;

  int checks   = 0;
  int failures = 0;
  int rw_clash = 0;
  int ack_rise_lat = 0;

  logic [31:0] mem_w [0:8];
  logic        sync_r, ack_r;
  int          lag_cnt;
  logic [9:0]  trace [$];
  logic [9:0]  exp_trace [0:18];

  corr_host_master #(.POLL_LIMIT(8)) dut (
    .clk(clk), .reset(reset), .start(start),
    .tmpl_data(tmpl_data), .sig_data(sig_data),
    .address(address), .write(write), .writedata(writedata),
    .read(read), .readdata(readdata),
    .busy(busy), .done(done), .err(err),
    .result0(result0), .result1(result1), .result2(result2), .result3(result3)
  );

  always #5 clk = ~clk;

  // Slave register file: template/signal words and sync.
  always @(posedge clk) begin
    if (write && (address <= 8'h08)) mem_w[address[3:0]] <= writedata;
  end

  // ack follows sync; the rise is delayed by ack_rise_lat extra cycles.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r  <= 1'b0;
      ack_r   <= 1'b0;
      lag_cnt <= 0;
    end else begin
      if (write && (address == 8'h0A)) sync_r <= writedata[0];
      if (sync_r != ack_r) begin
        if (!sync_r || (lag_cnt >= ack_rise_lat)) begin
          ack_r   <= sync_r;
          lag_cnt <= 0;
        end else begin
          lag_cnt <= lag_cnt + 1;
        end
      end
    end
  end

  function automatic logic [31:0] corr(input int lag);
    int  acc;
    int  si;
    byte tv, sv;
    acc = 0;
    for (int i = 0; i < 16; i++) begin
      si  = i + lag;
      tv  = byte'(mem_w[i / 4][8 * (i % 4) +: 8]);
      sv  = byte'(mem_w[4 + si / 4][8 * (si % 4) +: 8]);
      acc += int'(tv) * int'(sv);
    end
    return 32'(acc);
  endfunction

  always_comb begin
    readdata = '0;
    if (read) begin
      if (address == 8'h0B) readdata = {31'd0, ack_r};
      else if ((address >= 8'h10) && (address <= 8'h13)) readdata = corr(int'(address - 8'h10));
    end
  end

  // Bus trace: {write, read, address} per active cycle.
  always @(posedge clk) begin
    if (read && write) rw_clash++;
    if (read || write) trace.push_back({write, read, address});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] fill_t(input logic [7:0] b);
    return {16{b}};
  endfunction

  function automatic logic [159:0] fill_s(input logic [7:0] b);
    return {20{b}};
  endfunction

  function automatic logic [159:0] ramp_s();
    logic [159:0] s;
    for (int j = 0; j < 20; j++) s[8 * j +: 8] = 8'(j + 1);
    return s;
  endfunction

  // Starts a job and returns the cycle (relative to the start edge) in which done was seen.
  task automatic run_job(input logic [127:0] t, input logic [159:0] s, input int rise_lat,
                         input bit glitch, input int abort_at, input int budget,
                         output int done_cyc);
    done_cyc     = 0;
    ack_rise_lat = rise_lat;
    trace.delete();
    tmpl_data = t;
    sig_data  = s;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= budget; n++) begin
      if (n == abort_at) return;
      if (glitch && ((n == 5) || (n == 15))) begin
        start     = 1'b1;
        tmpl_data = ~t;
        sig_data  = ~s;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        done_cyc = n;
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (done_cyc != 0) begin
      @(posedge clk); #1;
      check("done_one_cycle", 32'(done), 32'd0);
      check("busy_after_done", 32'(busy), 32'd0);
    end
  endtask

  task automatic check_results(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                               input logic [31:0] e2, input logic [31:0] e3);
    check({tag, "_r0"}, result0, e0);
    check({tag, "_r1"}, result1, e1);
    check({tag, "_r2"}, result2, e2);
    check({tag, "_r3"}, result3, e3);
  endtask

  initial begin
    int dc;
    for (int i = 0; i < 9; i++) exp_trace[i] = {2'b10, 8'(i)};
    exp_trace[9]  = {2'b10, 8'h0A};
    exp_trace[10] = {2'b01, 8'h0B};
    exp_trace[11] = {2'b01, 8'h0B};
    for (int i = 0; i < 4; i++) exp_trace[12 + i] = {2'b01, 8'(8'h10 + 8'(i))};
    exp_trace[16] = {2'b10, 8'h0A};
    exp_trace[17] = {2'b01, 8'h0B};
    exp_trace[18] = {2'b01, 8'h0B};

    reset = 1'b1; start = 1'b0; tmpl_data = '0; sig_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_bus", {22'd0, write, read, address}, 32'd0);
    check("rst_wdata", writedata, 32'd0);
    check_results("rst", 32'd0, 32'd0, 32'd0, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Nominal job
    run_job(fill_t(8'h01), ramp_s(), 0, 1'b0, 0, 200, dc);
    check("nom_done_cycle", 32'(dc), 32'd20);
    check_results("nom", 32'd136, 32'd152, 32'd168, 32'd184);
    check("nom_trace_len", 32'(trace.size()), 32'd19);
    for (int i = 0; i < 19; i++) begin
      if (i < trace.size()) check($sformatf("nom_trace_%0d", i), 32'(trace[i]), 32'(exp_trace[i]));
    end
    check("nom_err", 32'(err), 32'd0);

    // Signed extremes
    run_job(fill_t(8'h80), fill_s(8'h80), 0, 1'b0, 0, 200, dc);
    check("neg_done_cycle", 32'(dc), 32'd20);
    check_results("negneg", 32'h0004_0000, 32'h0004_0000, 32'h0004_0000, 32'h0004_0000);
    run_job(fill_t(8'h7F), fill_s(8'h80), 0, 1'b0, 0, 200, dc);
    check_results("posneg", 32'hFFFC_0800, 32'hFFFC_0800, 32'hFFFC_0800, 32'hFFFC_0800);

    // start pulses mid-job with different data are ignored
    run_job(fill_t(8'h80), fill_s(8'h80), 0, 1'b1, 0, 200, dc);
    check("glitch_done_cycle", 32'(dc), 32'd20);
    check_results("glitch", 32'h0004_0000, 32'h0004_0000, 32'h0004_0000, 32'h0004_0000);

    // Reset during result reads
    run_job(fill_t(8'h01), ramp_s(), 0, 1'b0, 14, 200, dc);
    check("mid_r0_captured", result0, 32'd136);
    check("mid_r1_pending", result1, 32'h0004_0000);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_bus", {22'd0, write, read, address}, 32'd0);
    check_results("mid_rst", 32'd0, 32'd0, 32'd0, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    run_job(fill_t(8'h01), ramp_s(), 0, 1'b0, 0, 200, dc);
    check("post_rst_done_cycle", 32'(dc), 32'd20);
    check_results("post_rst", 32'd136, 32'd152, 32'd168, 32'd184);

    // Slow ack: 50 extra polls
    run_job(fill_t(8'h01), ramp_s(), 50, 1'b0, 0, 300, dc);
    check("slow_done_cycle", 32'(dc), 32'd70);
    check_results("slow", 32'd136, 32'd152, 32'd168, 32'd184);

    // ack never rises
`ifdef CORR_HOST_TIMEOUT_EN
    run_job(fill_t(8'h80), fill_s(8'h80), 32'h7FFF_FFFF, 1'b0, 0, 200, dc);
    check("tmo_done_cycle", 32'(dc), 32'd20);
    check("tmo_err", 32'(err), 32'd1);
    check("tmo_sync_cleared", 32'(sync_r), 32'd0);
    check("tmo_trace_len", 32'(trace.size()), 32'd19);
    if (trace.size() == 19) check("tmo_trace_last", 32'(trace[18]), 32'({2'b10, 8'h0A}));
    check_results("tmo", 32'd136, 32'd152, 32'd168, 32'd184);
`else
    run_job(fill_t(8'h80), fill_s(8'h80), 32'h7FFF_FFFF, 1'b0, 0, 100, dc);
    check("hang_no_done", 32'(dc), 32'd0);
    check("hang_busy", 32'(busy), 32'd1);
    check("hang_err", 32'(err), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
`endif

    // Next job clears err and runs normally
    run_job(fill_t(8'h7F), fill_s(8'h80), 0, 1'b0, 0, 200, dc);
    check("final_done_cycle", 32'(dc), 32'd20);
    check("final_err", 32'(err), 32'd0);
    check_results("final", 32'hFFFC_0800, 32'hFFFC_0800, 32'hFFFC_0800, 32'hFFFC_0800);

    check("rw_exclusive", 32'(rw_clash), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/corr_host_master.md
# corr_host_master

Bus-master sequencer that drives one correlation job on the correlation coprocessor's 8-bit-address, 32-bit-data memory-mapped slave port. On `start` it snapshots 16 template bytes and 20 signal bytes and writes them to the coprocessor. It then raises sync, polls ack, and reads the four 32-bit correlation lags. Finally it drops sync and waits for ack to clear, leaving the slave ready for the next job. It sits between the local control logic and the coprocessor, replacing software-driven register pokes.

## Interface
- `POLL_LIMIT`, default 1023: maximum ack polls per poll phase before timeout. Used only with `CORR_HOST_TIMEOUT_EN`.
- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high.
- `start` in 1: job request. Sampled only in IDLE.
- `tmpl_data` in 128: template. Word k = bits [32k+31:32k], k = 0..3. Byte 0 of word k is template element 4k+1.
- `sig_data` in 160: signal samples, words 0..4, same packing.
- `address` out 8: slave address.
- `write` out 1: slave write strobe, one cycle per access.
- `writedata` out 32: slave write data.
- `read` out 1: slave read strobe.
- `readdata` in 32: slave read data. Zero-wait; valid in the same cycle as `read`.
- `busy` out 1: job in progress.
- `done` out 1: one-cycle pulse when a job completes.
- `err` out 1: sticky poll timeout flag. Cleared on the next accepted `start`.
- `result0`..`result3` out 32 each: signed lag 0..3 results. Hold until overwritten.

## Operation
Slave register map:
- 0x0–0x3: template words 0–3.
- 0x4–0x8: signal words 0–4.
- 0xA: sync, bit 0.
- 0xB: ack, bit 0, read-only.
- 0x10–0x13: lag 0–3 results.

States and transitions:
- **IDLE**
  - On `start`: snapshot `tmpl_data`/`sig_data` into internal registers, clear `err`, set `busy`, go to WR_DATA.
  - Later changes on the inputs do not affect the current job.
- **WR_DATA**: 9 consecutive writes, one per cycle, addresses 0x0..0x8 in order, using the snapshot words. A 4-bit index counts 0..8. Go to WR_SYNC1.
- **WR_SYNC1**: write 0x00000001 to 0xA. Go to POLL1.
- **POLL1**: read 0xB every cycle.
  - `readdata[0]`=1 → RD_RES.
  - Otherwise stay.
- **RD_RES**: 4 consecutive reads, addresses 0x10..0x13. At each read's closing edge, capture `readdata` into `result0`..`result3` respectively. Go to WR_SYNC0.
- **WR_SYNC0**: write 0x00000000 to 0xA. Go to POLL0.
- **POLL0**: read 0xB every cycle.
  - `readdata[0]`=0 → DONE.
  - Otherwise stay.
- **DONE**: `done`=1 for one cycle, `busy`=0, go to IDLE.

Bus and control rules:
- `read` and `write` are never high together.
- Idle bus: `address`=0, `writedata`=0, strobes 0.
- Bus outputs are driven from registered state, index and snapshot only. There is no combinational path from `start`/`readdata` to bus outputs.
- `start` while `busy` is ignored. No queuing.
- Results are passed through raw (two's complement). No saturation.

Reset behaviour:
- Reset asserted at any time returns immediately to IDLE.
- `busy`/`done`/`err`=0, all results 0, all bus outputs 0, snapshot cleared.
- A partially captured result set is discarded to 0.

## Timing
- `start` sampled at edge E0. First write (0x0) occurs in cycle E0+1.
- Writes occupy cycles 1–9; sync=1 write in cycle 10.
- Against the nominal slave, ack reads 0 on the first poll (cycle 11) and 1 on the second (cycle 12).
- Result reads occupy cycles 13–16; sync=0 write in cycle 17.
- POLL0 sees ack=1 in cycle 18 and 0 in cycle 19.
- `done` high in cycle 20. The next `start` can be accepted in cycle 21.
- Polls are unbounded in count without the timeout feature. Latency grows one cycle per extra poll.

## Configuration
- `CORR_HOST_TIMEOUT_EN` defined:
  - A poll counter, reset on entering each poll state, counts reads in POLL1/POLL0.
  - When it reaches `POLL_LIMIT` without the expected ack value: set `err`=1, write 0 to 0xA, pulse `done`, return to IDLE.
  - Results are left unchanged by a timed-out job.
- Not defined: no counter. Polling continues indefinitely, and `err` is tied to 0.

## Test plan
- **Reset**: assert `reset` mid-RD_RES (after `result0` captured) → all outputs 0 in the same cycle, state IDLE; a following job completes normally.
- **Nominal job**: template bytes all 0x01, signal bytes 1..20 → results 136, 152, 168, 184; `done` exactly 20 cycles after `start`; bus trace addresses 0..8, A, B, B, 10..13, A, B, B.
- **Signed extremes**: all template and signal bytes 0x80 → each result 0x00040000. Template 0x7F with signal 0x80 → each result 0xFFFC0800.
- **Start during job**: pulse `start` in cycles 5 and 15 with changed data → ignored; results match the originally snapshotted data.
- **Slow ack**: responder model delays ack by 50 cycles → 50 extra polls, correct results, `done` 70 cycles after `start`.
- **Timeout (macro on, POLL_LIMIT=8)**: ack held 0 → after 8 polls `err`=1, sync-clear write, `done` pulse, results unchanged. With the macro off → `busy` stays 1.
